// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if
// Request/response bus between the MEM-stage load/store initiator and data memory.
//   bus_valid/bus_ready : request handshake (master drives valid, slave drives ready)
//   bus_addr            : word-aligned byte address
//   bus_we              : 1 = write, 0 = read
//   bus_be              : byte enables, bit n selects bits 8n+7:8n
//   bus_wdata           : lane-replicated write data
//   bus_rvalid          : response strobe; acknowledges writes as well as reads
//   bus_rdata           : read word
interface mem_bus_master_if;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master
// Turns the MEM-stage load/store controls into a single valid/ready bus transaction with a
// variable-latency response, stalling the pipeline until the access completes. Load data is
// lane-extracted and extended here; misaligned accesses and response timeouts complete
// without a hang and raise a one-cycle error pulse.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   mem_rd, mem_wr       : load / store request (store wins if both)
//   Address, DI          : byte address, store data
//   Savesel              : 0 sw, 1 sh, 2 sb, 3 sw
//   Readsel              : 0 lw, 1 lhu, 2 lh, 3 lbu, 4 lb, 5-7 lw
//   stall                : freeze the pipeline
//   done                 : one-cycle completion pulse
//   DMout                : registered, extended load result
//   addr_err, bus_err    : one-cycle misalignment / timeout pulses (coincide with done)
//   bus                  : request/response bus (master side)
module mem_bus_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] Address,
  input  logic [31:0] DI,
  input  logic [1:0]  Savesel,
  input  logic [2:0]  Readsel,
  output logic        stall,
  output logic        done,
  output logic [31:0] DMout,
  output logic        addr_err,
  output logic        bus_err,
  mem_bus_master_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [29:0]   r_addr;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [1:0]    r_lo;
  logic [2:0]    r_rsel;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_dmout;
  logic          r_addr_err;
  logic          r_bus_err;

  logic          w_start;
  logic          w_word;
  logic          w_half;
  logic          w_misalign;
  logic          w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [15:0]   w_half_sel;
  logic [7:0]    w_byte_sel;
  logic [31:0]   w_rd_ext;

  assign w_start   = (r_state == StIdle) && (mem_rd || mem_wr);
  assign w_timeout = (r_cnt == CW'(TIMEOUT));

  // Access size decode; the store controls take over whenever mem_wr is set.
  always_comb begin
    w_word = 1'b0;
    w_half = 1'b0;
    if (mem_wr) begin
      w_word = (Savesel == 2'd0) || (Savesel == 2'd3);
      w_half = (Savesel == 2'd1);
    end else begin
      w_word = (Readsel == 3'd0) || (Readsel > 3'd4);
      w_half = (Readsel == 3'd1) || (Readsel == 3'd2);
    end
  end

  assign w_misalign = (w_word && (Address[1:0] != 2'b00)) || (w_half && Address[0]);

  // Byte enables and replicated write data for the request being launched.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (mem_wr) begin
      case (Savesel)
        2'd1: begin
          w_be    = Address[1] ? 4'b1100 : 4'b0011;
          w_wdata = {DI[15:0], DI[15:0]};
        end
        2'd2: begin
          w_be    = 4'b0001 << Address[1:0];
          w_wdata = {4{DI[7:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = DI;
        end
      endcase
    end
  end

  // Lane select and extension of the response word using the latched offset and type.
  always_comb begin
    w_half_sel = r_lo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    w_byte_sel = 8'h0;
    case (r_lo)
      2'd0:    w_byte_sel = bus.bus_rdata[7:0];
      2'd1:    w_byte_sel = bus.bus_rdata[15:8];
      2'd2:    w_byte_sel = bus.bus_rdata[23:16];
      default: w_byte_sel = bus.bus_rdata[31:24];
    endcase
    case (r_rsel)
      3'd1:    w_rd_ext = {16'h0, w_half_sel};
      3'd2:    w_rd_ext = {{16{w_half_sel[15]}}, w_half_sel};
      3'd3:    w_rd_ext = {24'h0, w_byte_sel};
      3'd4:    w_rd_ext = {{24{w_byte_sel[7]}}, w_byte_sel};
      default: w_rd_ext = bus.bus_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = w_misalign ? StDone : StReq;
        end
      end
      StReq: begin
        if (bus.bus_ready) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (bus.bus_rvalid || w_timeout) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        // mem_rd/mem_wr are still high for the completing instruction; never reissue it.
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_addr     <= 30'h0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_lo       <= 2'b00;
      r_rsel     <= 3'd0;
      r_cnt      <= '0;
      r_dmout    <= 32'h0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            if (w_misalign) begin
              r_addr_err <= 1'b1;
              r_dmout    <= 32'h0;
            end else begin
              r_addr  <= Address[31:2];
              r_we    <= mem_wr;
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_lo    <= Address[1:0];
              r_rsel  <= Readsel;
            end
          end
        end
        StReq: begin
          if (bus.bus_ready) begin
            r_cnt <= '0;
          end
        end
        StResp: begin
          r_cnt <= r_cnt + CW'(1);
          // A response arriving on the last allowed cycle still wins over the timeout.
          if (bus.bus_rvalid) begin
            if (!r_we) begin
              r_dmout <= w_rd_ext;
            end
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_dmout   <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall    = w_start || (r_state == StReq) || (r_state == StResp);
  assign done     = (r_state == StDone);
  assign DMout    = r_dmout;
  assign addr_err = r_addr_err;
  assign bus_err  = r_bus_err;

  assign bus.bus_valid = (r_state == StReq);
  assign bus.bus_addr  = {r_addr, 2'b00};
  assign bus.bus_we    = r_we;
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Load/store initiator for the MEM stage of the pipelined MIPS CPU. It takes the same load/store controls that drive the single-cycle data memory: `Address`, `DI`, `Savesel` and `Readsel`. It issues them as word-aligned, byte-enabled transactions on a valid/ready request bus with a variable-latency response, and stalls the pipeline until the response arrives. Read data is extracted and extended in-block. Misaligned accesses and bus timeouts are flagged without hanging the CPU.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles waited in RESP for `bus_rvalid` before aborting.
- `CW`, default 8: width of the timeout counter. Must satisfy TIMEOUT < 2^CW.

Ports:
- `clk` in 1: the only clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_rd` in 1: load request from the MEM stage.
- `mem_wr` in 1: store request. Wins if asserted together with `mem_rd`.
- `Address` in 32: byte address.
- `DI` in 32: store data, taken from the low bits for sh/sb.
- `Savesel` in 2: 0 sw, 1 sh, 2 sb, 3 treated as sw.
- `Readsel` in 3: 0 lw, 1 lhu, 2 lh, 3 lbu, 4 lb, 5-7 treated as lw.
- `stall` out 1: freeze the PC and the IF/ID/EX/MEM registers.
- `done` out 1: one-cycle pulse when the access completes.
- `DMout` out 32: extended load result, registered.
- `addr_err` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: one-cycle pulse on a timeout.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: request accepted.
- `bus_addr` out 32: `{Address[31:2],2'b00}`.
- `bus_we` out 1: write request.
- `bus_be` out 4: byte enables; bit n selects bits 8n+7:8n.
- `bus_wdata` out 32: lane-replicated write data.
- `bus_rvalid` in 1: response valid. Also acknowledges writes.
- `bus_rdata` in 32: read word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- `start` = IDLE & (`mem_rd` | `mem_wr`).
- Alignment check:
  - Word accesses (sw, lw) require `Address[1:0]`==0.
  - Halfword accesses (sh, lh, lhu) require `Address[0]`==0.
  - Byte accesses never fault.
- IDLE, start and misaligned:
  - Go to DONE with `addr_err` set.
  - No bus transaction.
  - `DMout` is cleared to 0.
- IDLE, start and aligned: latch into internal registers, then go to REQ. Latched fields:
  - `bus_addr`, `bus_we`, the low two address bits, `Readsel`.
  - `bus_be`:
    - sw: 1111.
    - sh: 0011 when `Address[1]`=0, 1100 when `Address[1]`=1.
    - sb: 0001 << `Address[1:0]`.
    - Loads: 1111.
  - `bus_wdata`:
    - sw: `DI`.
    - sh: `{DI[15:0],DI[15:0]}`.
    - sb: `{4{DI[7:0]}}`.
- REQ:
  - `bus_valid`=1.
  - All bus outputs stay stable until `bus_ready`=1.
  - On the handshake go to RESP, clear the counter, and drop `bus_valid` next cycle.
- RESP:
  - The counter increments each cycle.
  - `bus_rvalid`=1 goes to DONE. For loads, `DMout` <= extract(`bus_rdata`):
    - lw: the whole word.
    - lhu/lh: the half selected by `Address[1]`, zero- or sign-extended from its bit 15.
    - lbu/lb: the byte selected by `Address[1:0]`, zero- or sign-extended from its bit 7.
  - For stores, `DMout` holds its previous value.
  - Counter reaching TIMEOUT without `bus_rvalid` goes to DONE with `bus_err`=1 and `DMout`=0.
- DONE:
  - `done`=1 and `stall`=0.
  - Always returns to IDLE.
  - `mem_rd`/`mem_wr` are ignored, so the completing instruction is never reissued.
- `stall` = `start` | (state==REQ) | (state==RESP). This is combinational from the inputs in IDLE only.
- `bus_rvalid` is ignored outside RESP. `bus_ready` is ignored outside REQ.

## Timing
- Reset values: state IDLE, `stall`/`done`/`addr_err`/`bus_err`/`bus_valid`/`bus_we`=0, `bus_be`=0, `bus_addr`/`bus_wdata`/`DMout`=0, counter 0.
- Reset mid-transaction:
  - IDLE on the next edge.
  - `bus_valid` low from that edge.
  - Any late `bus_rvalid` is ignored.
- Best-case aligned access: start at cycle 0, REQ in cycle 1 (`bus_ready` high), RESP in cycle 2 (`bus_rvalid` high), DONE in cycle 3.
  - `stall` is high in cycles 0-2.
  - `done` and `DMout` are valid in cycle 3.
- A misaligned access takes 1 stall cycle (cycle 0); `done`/`addr_err` pulse in cycle 1.
- Timeout: DONE comes TIMEOUT+1 cycles after entering RESP.
- `DMout` holds between completions.

## Test plan
- Bus memory preloaded with 0x8000_7F80 at 0x100:
  - lb at 0x100 -> `DMout`=0xFFFF_FF80.
  - lbu at 0x100 -> `DMout`=0x0000_0080.
  - lh at 0x102 -> `DMout`=0xFFFF_8000.
  - lhu at 0x100 -> `DMout`=0x0000_7F80.
  - lw at 0x100 -> `DMout`=0x8000_7F80.
- sb at 0x203 with `DI`=0x1234_56AB -> `bus_be`=1000, `bus_wdata`=0xABAB_ABAB, `bus_addr`=0x200, `bus_we`=1.
- sh at 0x202 with `DI`=0xDEAD_BEEF -> `bus_be`=1100, `bus_wdata`=0xBEEF_BEEF.
- lw at 0x101 -> `addr_err` pulse, `bus_valid` never rises, `DMout`=0, `done` 1 cycle after the request.
- Backpressure: `bus_ready` held low for 3 cycles and `bus_rvalid` delayed by 5 -> bus outputs stable throughout REQ, `stall` continuous until DONE, exactly one `done` pulse.
- TIMEOUT=4 with `bus_rvalid` never asserted -> `bus_err`+`done` 5 cycles after entering RESP, `DMout`=0.
- `reset` asserted while in RESP -> IDLE with `bus_valid`/`stall` low next cycle, and a later `bus_rvalid` produces no `done`.
